// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the CPU front end.
//   fetch_state_t : fetch FSM states (FETCH, HOLD, HALTED)
//   ifid_t        : IF/ID pipeline bundle {valid, imemload, pc, npc}
//   PC_STEP       : byte increment per sequential fetch
package cpu_types_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] imemload;
    logic [31:0] pc;
    logic [31:0] npc;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '0;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry holding register for one fetched instruction that arrived
// while decode was stalled.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (empties the entry)
//   load_i   : capture data_i and mark the entry full
//   drain_i  : entry has been consumed, mark it empty
//   clear_i  : discard the entry (redirect / halt); wins over load and drain
//   data_i   : bundle to capture
//   valid_o  : entry holds an instruction
//   data_o   : buffered bundle
module fetch_skid_buf
  import cpu_types_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  logic  drain_i,
  input  logic  clear_i,
  input  ifid_t data_i,
  output logic  valid_o,
  output ifid_t data_o
);

  logic  valid_q, valid_d;
  ifid_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= IFID_BUBBLE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and
// produces the IF/ID bundle. Handles decode stall (via a one-entry skid),
// global freeze, downstream redirects and a permanent halt.
//   CLK, RST                  : clock, synchronous active-high reset
//   ihit, imemload            : memory response for the current request
//   imemREN, imemaddr         : memory request (address is always the PC)
//   stall_id                  : decode hazard, hold IF/ID and PC
//   freeze                    : hold every register
//   redirect, redirect_pc     : control-flow redirect from later stages
//   halt_in                   : committed halt, stop fetching until reset
//   id_valid/id_imemload/id_pc/id_npc : IF/ID bundle
//   halted                    : fetch permanently stopped
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [31:0] PC_STEP = cpu_types_pkg::PC_STEP
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall_id,
  input  logic        freeze,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_in,
  output logic        id_valid,
  output logic [31:0] id_imemload,
  output logic [31:0] id_pc,
  output logic [31:0] id_npc,
  output logic        halted
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  ifid_t        ifid_q, ifid_d;

  logic  skid_load, skid_drain, skid_clear, skid_valid;
  ifid_t skid_data, fetched;

  // Targets are word aligned; the low two bits of redirect_pc are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign fetched = '{valid: 1'b1, imemload: imemload, pc: pc_q, npc: pc_q + PC_STEP};

  fetch_skid_buf u_skid (
    .clk_i   (CLK),
    .rst_i   (RST),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .data_i  (fetched),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_d     = ifid_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;

    if (halt_in) begin
      state_d    = HALTED;
      ifid_d     = IFID_BUBBLE;
      skid_clear = 1'b1;
    end else if (state_q == HALTED || freeze) begin
      // HALTED only leaves through reset; freeze holds everything.
    end else if (redirect) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      ifid_d     = IFID_BUBBLE;
      skid_clear = 1'b1;
      state_d    = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!stall_id) begin
            if (ihit) begin
              ifid_d = fetched;
              pc_d   = pc_q + PC_STEP;
            end else begin
              ifid_d = IFID_BUBBLE;
            end
          end else if (ihit) begin
            // Decode can't take it yet: park it so it is neither lost nor refetched.
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
        HOLD: begin
          if (!stall_id) begin
            ifid_d       = skid_data;
            ifid_d.valid = skid_valid;
            skid_drain   = 1'b1;
            pc_d         = pc_q + PC_STEP;
            state_d      = FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      ifid_q  <= IFID_BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  assign imemaddr    = pc_q;
  assign imemREN     = (state_q == FETCH) && !freeze;
  assign halted      = (state_q == HALTED);
  assign id_valid    = ifid_q.valid;
  assign id_imemload = ifid_q.imemload;
  assign id_pc       = ifid_q.pc;
  assign id_npc      = ifid_q.npc;

endmodule
